note_lane_scroller: RTL
=======================

Name: note_lane_scroller

Overview:
- Per-lane falling-note state engine for one guitar lane.
- Holds up to NUM_SLOTS active notes. Spawns a note on request and advances every note's y position once per video frame.
- Retires a note as a miss when it passes the bottom of the screen, or as a hit when the player strums inside the hit window.
- Feeds one note-bounds checker per slot in the pixel path: constant note_x, per-slot note_y, per-slot valid.

Parameters:
- NUM_SLOTS, 4, number of concurrent notes tracked in the lane (1..8)
- LANE_X, 10'd100, left x coordinate of the lane, driven on note_x
- SPEED, 4, pixels added to each active note_y per frame_tick (1..15)
- BOTTOM_Y, 480, note retires as a miss once its advanced y is >= BOTTOM_Y
- HIT_LO, 400, lower bound of the hit window, inclusive
- HIT_HI, 440, upper bound of the hit window, inclusive

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse per frame (start of vblank)
- spawn  in  1  one-cycle pulse: insert a new note at y=0
- hit_req  in  1  one-cycle strum pulse for this lane
- pause  in  1  when high, frame_tick is ignored; spawn and hit_req still honoured
- note_x  out  10  constant LANE_X
- note_y_bus  out  12*NUM_SLOTS  slot i y position at bits [12*i+11 : 12*i]
- slot_valid  out  NUM_SLOTS  slot i holds an active note
- hit_ok  out  1  registered pulse: strum removed a note
- hit_bad  out  1  registered pulse: strum found no note in the window
- miss  out  1  registered pulse: at least one note retired off the bottom this tick
- overflow  out  1  registered pulse: spawn dropped because all slots were busy
- hit_count  out  8  saturating count of hit_ok events
- miss_count  out  8  saturating count of retired notes, counted per note

Behaviour:
- Reset (resetn low, asynchronous): all slot_valid=0; all note_y=0; hit_ok, hit_bad, miss, overflow = 0; hit_count=0; miss_count=0. note_x is always LANE_X.
- All outputs are registered. Event pulses assert exactly one cycle after the triggering input cycle. Slot state updates on the same edge.
- Every evaluation in a cycle uses the pre-edge slot state S.

Hit (hit_req=1):
- Candidates are valid slots in S with HIT_LO <= y <= HIT_HI.
- If any candidate exists: clear the candidate with the largest y (ties go to the lowest index), pulse hit_ok, and increment hit_count, saturating at 255.
- If no candidate exists: pulse hit_bad.

Advance (frame_tick=1 and pause=0):
- Each valid slot in S not cleared by a hit this cycle computes y' = y + SPEED, using 12-bit arithmetic with no wrap possible inside the parameter ranges.
- If y' >= BOTTOM_Y: clear the slot.
- Otherwise: store y'.
- If k >= 1 slots retire this cycle: pulse miss once, and add k to miss_count, saturating at 255.

Spawn (spawn=1):
- Target is the lowest-index slot that is invalid in S. Slots freed this same cycle are not eligible.
- The target becomes valid with y=0 and does not advance in its spawn cycle.
- If no slot is invalid in S: drop the spawn and pulse overflow.

Simultaneous events and mid-operation reset:
- A hit, an advance and a spawn may all occur in one cycle; each follows the rules above independently.
- A note cleared by a hit is never also counted as a miss.
- Reset mid-operation clears all state immediately. No pulses are emitted on reset release.

Sizing:
- Pure datapath of NUM_SLOTS registers, a priority encoder for the free slot, and a max-select for the hit candidate.
- No internal FSM beyond the per-slot valid bits.

Test Plan:
- Reset, spawn, then 100 frame_ticks -> slot0 valid, y=400. hit_req -> next cycle hit_ok=1, slot_valid=0, hit_count=1.
- Spawn, then 120 frame_ticks -> on the 120th tick y'=480, slot cleared, miss=1 for one cycle, miss_count=1. hit_req afterwards -> hit_bad=1.
- Spawn 4 times on separate cycles, then spawn a 5th -> slot_valid=4'b1111, overflow=1, no state change.
- Two notes at y=404 and y=420, then hit_req -> slot with y=420 cleared, y=404 remains. hit_req and frame_tick in the same cycle -> hit uses 404, that slot clears, no advance on it, no miss.
- Hold pause=1 across 10 frame_ticks -> y unchanged. Spawn in the same cycle as frame_tick -> new slot y=0 and other slots advance by 4.
- Drive resetn low with 3 notes active mid-frame -> outputs zero asynchronously. Release reset -> no pulses; counters stay 0.

Source files
------------

// File: rtl/note_lane_scroller.sv
// note_lane_scroller: falling-note slot engine for one guitar lane (spawn, per-frame advance, strum hit, miss retire)
module note_lane_scroller #(
  parameter int         NUM_SLOTS = 4,
  parameter logic [9:0] LANE_X    = 10'd100,
  parameter int         SPEED     = 4,
  parameter int         BOTTOM_Y  = 480,
  parameter int         HIT_LO    = 400,
  parameter int         HIT_HI    = 440
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    frame_tick,
  input  logic                    spawn,
  input  logic                    hit_req,
  input  logic                    pause,
  output logic [9:0]              note_x,
  output logic [12*NUM_SLOTS-1:0] note_y_bus,
  output logic [NUM_SLOTS-1:0]    slot_valid,
  output logic                    hit_ok,
  output logic                    hit_bad,
  output logic                    miss,
  output logic                    overflow,
  output logic [7:0]              hit_count,
  output logic [7:0]              miss_count
);
  logic [NUM_SLOTS-1:0] valid_q, valid_d;
  logic [11:0]          y_q [NUM_SLOTS];
  logic [11:0]          y_d [NUM_SLOTS];
  logic                 hit_ok_q, hit_ok_d, hit_bad_q, hit_bad_d;
  logic                 miss_q, miss_d, overflow_q, overflow_d;
  logic [7:0]           hit_count_q, hit_count_d, miss_count_q, miss_count_d;
  logic                 found, free_any, adv;
  logic [11:0]          best_y;
  int                   best, free_i;
  logic [3:0]           k;
  logic [8:0]           miss_sum;
  always_comb begin
    found = 1'b0;
    best = 0;
    best_y = '0;
    free_any = 1'b0;
    free_i = 0;
    k = '0;
    adv = frame_tick && !pause;
    // strict '>' keeps the lowest index on equal y
    for (int i = 0; i < NUM_SLOTS; i++)
      if (valid_q[i] && y_q[i] >= 12'(HIT_LO) && y_q[i] <= 12'(HIT_HI) && (!found || y_q[i] > best_y)) begin
        found = 1'b1;
        best = i;
        best_y = y_q[i];
      end
    for (int i = NUM_SLOTS - 1; i >= 0; i--)
      if (!valid_q[i]) begin
        free_any = 1'b1;
        free_i = i;
      end
    for (int i = 0; i < NUM_SLOTS; i++) begin
      valid_d[i] = valid_q[i];
      y_d[i] = y_q[i];
      if (hit_req && found && i == best)
        valid_d[i] = 1'b0;
      else if (adv && valid_q[i]) begin
        if (y_q[i] + 12'(SPEED) >= 12'(BOTTOM_Y)) begin
          valid_d[i] = 1'b0;
          k = k + 4'd1;
        end else
          y_d[i] = y_q[i] + 12'(SPEED);
      end
      // the spawn target was invalid in the pre-edge state, so it never collides with hit/advance
      if (spawn && free_any && i == free_i) begin
        valid_d[i] = 1'b1;
        y_d[i] = '0;
      end
    end
    hit_ok_d = hit_req && found;
    hit_bad_d = hit_req && !found;
    miss_d = k != 4'd0;
    overflow_d = spawn && !free_any;
    hit_count_d = (hit_ok_d && hit_count_q != 8'hff) ? hit_count_q + 8'd1 : hit_count_q;
    miss_sum = {1'b0, miss_count_q} + 9'(k);
    miss_count_d = miss_sum[8] ? 8'hff : miss_sum[7:0];
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
      y_q <= '{default: '0};
      hit_ok_q <= 1'b0;
      hit_bad_q <= 1'b0;
      miss_q <= 1'b0;
      overflow_q <= 1'b0;
      hit_count_q <= '0;
      miss_count_q <= '0;
    end else begin
      valid_q <= valid_d;
      y_q <= y_d;
      hit_ok_q <= hit_ok_d;
      hit_bad_q <= hit_bad_d;
      miss_q <= miss_d;
      overflow_q <= overflow_d;
      hit_count_q <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end
  always_comb begin
    note_y_bus = '0;
    for (int i = 0; i < NUM_SLOTS; i++) note_y_bus[12*i +: 12] = y_q[i];
  end
  assign note_x = LANE_X;
  assign slot_valid = valid_q;
  assign hit_ok = hit_ok_q;
  assign hit_bad = hit_bad_q;
  assign miss = miss_q;
  assign overflow = overflow_q;
  assign hit_count = hit_count_q;
  assign miss_count = miss_count_q;
endmodule
